// File: rtl/wasm_pkg.sv
// wasm_pkg: shared definitions for the WASM core's local-variable controller.
//   local_op_e   - encodings of the req_op field (GET / SET / TEE / reserved)
//   trap_code_e  - values reported on trap_code
//   lc_state_e   - state encoding of the local-access FSM
package wasm_pkg;

   typedef enum logic [1:0] {
      LOCAL_GET  = 2'd0,
      LOCAL_SET  = 2'd1,
      LOCAL_TEE  = 2'd2,
      LOCAL_RSVD = 2'd3
   } local_op_e;

   typedef enum logic [1:0] {
      TRAP_NONE       = 2'd0,
      TRAP_FRAME_OVF  = 2'd1,
      TRAP_FRAME_UNF  = 2'd2,
      TRAP_IDX_RANGE  = 2'd3
   } trap_code_e;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StPush   = 2'd2
   } lc_state_e;

endpackage

// File: rtl/wasm_local_ctrl_if.sv
// wasm_local_ctrl_if: bundles every non-clock signal of wasm_local_ctrl.
//   request   : req_vld/req_rdy/req_op/req_idx
//   frame     : call_vld/call_nlocals/ret_vld
//   stack     : st_top_data/st_pop/st_push/st_push_data
//   memory    : mem_addr/mem_we/mem_wr_data/mem_rd_data
//   status    : done/trap/trap_code
// Modports:
//   master - environment side (decoder, operand stack, local BRAM)
//   slave  - the controller
interface wasm_local_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDX_WIDTH  = 32
) ();

   logic                  req_vld;
   logic                  req_rdy;
   logic [1:0]            req_op;
   logic [IDX_WIDTH-1:0]  req_idx;
   logic                  call_vld;
   logic [IDX_WIDTH-1:0]  call_nlocals;
   logic                  ret_vld;
   logic [DATA_WIDTH-1:0] st_top_data;
   logic                  st_pop;
   logic                  st_push;
   logic [DATA_WIDTH-1:0] st_push_data;
   logic [IDX_WIDTH-1:0]  mem_addr;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_wr_data;
   logic [DATA_WIDTH-1:0] mem_rd_data;
   logic                  done;
   logic                  trap;
   logic [1:0]            trap_code;

   modport master (
      output req_vld, req_op, req_idx, call_vld, call_nlocals, ret_vld, st_top_data,
             mem_rd_data,
      input  req_rdy, st_pop, st_push, st_push_data, mem_addr, mem_we, mem_wr_data,
             done, trap, trap_code
   );

   modport slave (
      input  req_vld, req_op, req_idx, call_vld, call_nlocals, ret_vld, st_top_data,
             mem_rd_data,
      output req_rdy, st_pop, st_push, st_push_data, mem_addr, mem_we, mem_wr_data,
             done, trap, trap_code
   );

endinterface

// File: rtl/local_frame_stack.sv
// local_frame_stack: FRAME_DEPTH-entry LIFO of saved {base, nlocals} frames.
//   clk, rst                 - clock, synchronous active-high reset (empties the stack)
//   push, push_base/nlocals  - save a frame (ignored when full)
//   pop                      - discard the top frame (ignored when empty)
//   top_base, top_nlocals    - most recently saved frame (valid when !empty)
//   full, empty              - occupancy flags
// FRAME_DEPTH must be a power of two and at least 2.
module local_frame_stack #(
   parameter int unsigned IDX_WIDTH   = 32,
   parameter int unsigned FRAME_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [IDX_WIDTH-1:0] push_base,
   input  logic [IDX_WIDTH-1:0] push_nlocals,
   output logic [IDX_WIDTH-1:0] top_base,
   output logic [IDX_WIDTH-1:0] top_nlocals,
   output logic                 full,
   output logic                 empty
);

   localparam int unsigned AW = $clog2(FRAME_DEPTH);
   localparam logic [AW:0]   DepthCnt = (AW+1)'(FRAME_DEPTH);
   localparam logic [AW-1:0] AwOne    = 1;

   // ptr_q counts occupied entries; the extra MSB distinguishes full from empty.
   logic [AW:0]          ptr_q;
   logic [AW-1:0]        wr_idx;
   logic [AW-1:0]        rd_idx;
   logic [IDX_WIDTH-1:0] base_mem    [FRAME_DEPTH];
   logic [IDX_WIDTH-1:0] nlocals_mem [FRAME_DEPTH];

   assign full        = (ptr_q == DepthCnt);
   assign empty       = (ptr_q == '0);
   assign wr_idx      = ptr_q[AW-1:0];
   assign rd_idx      = wr_idx - AwOne;
   assign top_base    = base_mem[rd_idx];
   assign top_nlocals = nlocals_mem[rd_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (push && !full) begin
         ptr_q <= ptr_q + 1'b1;
      end else if (pop && !empty) begin
         ptr_q <= ptr_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push && !full) begin
         base_mem[wr_idx]    <= push_base;
         nlocals_mem[wr_idx] <= push_nlocals;
      end
   end

endmodule

// File: rtl/wasm_local_ctrl.sv
// wasm_local_ctrl: executes local.get / local.set / local.tee against the single-port
// local BRAM (combinational read, clocked write) and tracks the call frame window.
//   clk, rst - clock, synchronous active-high reset
//   bus      - wasm_local_ctrl_if.slave: request, frame, stack, memory and status signals
// Optional feature: define LOCAL_BOUNDS_CHECK_EN to trap (code 3) on req_idx >= nlocals
// instead of accessing base + req_idx unchecked.
module wasm_local_ctrl
   import wasm_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned IDX_WIDTH    = 32,
   parameter int unsigned FRAME_DEPTH  = 16,
   parameter int unsigned INIT_NLOCALS = 2
) (
   input logic             clk,
   input logic             rst,
   wasm_local_ctrl_if.slave bus
);

   lc_state_e             state_q, state_d;
   local_op_e             op_q, op_d;
   logic [IDX_WIDTH-1:0]  idx_q, idx_d;
   logic [IDX_WIDTH-1:0]  base_q, base_d;
   logic [IDX_WIDTH-1:0]  nlocals_q, nlocals_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   // Last driven address / write data, so both hold outside ACCESS.
   logic [IDX_WIDTH-1:0]  addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   logic                  fs_push, fs_pop, fs_full, fs_empty;
   logic [IDX_WIDTH-1:0]  fs_top_base, fs_top_nlocals;
   logic                  idx_bad;

`ifdef LOCAL_BOUNDS_CHECK_EN
   assign idx_bad = (bus.req_idx >= nlocals_q);
`else
   assign idx_bad = 1'b0;
`endif

   local_frame_stack #(
      .IDX_WIDTH   (IDX_WIDTH),
      .FRAME_DEPTH (FRAME_DEPTH)
   ) u_frame_stack (
      .clk          (clk),
      .rst          (rst),
      .push         (fs_push),
      .pop          (fs_pop),
      .push_base    (base_q),
      .push_nlocals (nlocals_q),
      .top_base     (fs_top_base),
      .top_nlocals  (fs_top_nlocals),
      .full         (fs_full),
      .empty        (fs_empty)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      idx_d     = idx_q;
      base_d    = base_q;
      nlocals_d = nlocals_q;
      data_d    = data_q;
      fs_push   = 1'b0;
      fs_pop    = 1'b0;

      bus.req_rdy      = (state_q == StIdle) && !bus.call_vld && !bus.ret_vld;
      bus.mem_addr     = addr_q;
      bus.mem_we       = 1'b0;
      bus.mem_wr_data  = wdata_q;
      bus.st_pop       = 1'b0;
      bus.st_push      = 1'b0;
      bus.st_push_data = data_q;
      bus.done         = 1'b0;
      bus.trap         = 1'b0;
      bus.trap_code    = TRAP_NONE;

      unique case (state_q)
         StIdle: begin
            if (bus.call_vld) begin
               // A simultaneous ret is dropped.
               if (fs_full) begin
                  bus.trap      = 1'b1;
                  bus.trap_code = TRAP_FRAME_OVF;
               end else begin
                  fs_push   = 1'b1;
                  base_d    = base_q + nlocals_q;
                  nlocals_d = bus.call_nlocals;
                  bus.done  = 1'b1;
               end
            end else if (bus.ret_vld) begin
               if (fs_empty) begin
                  bus.trap      = 1'b1;
                  bus.trap_code = TRAP_FRAME_UNF;
               end else begin
                  fs_pop    = 1'b1;
                  base_d    = fs_top_base;
                  nlocals_d = fs_top_nlocals;
                  bus.done  = 1'b1;
               end
            end else if (bus.req_vld) begin
               if (idx_bad) begin
                  bus.trap      = 1'b1;
                  bus.trap_code = TRAP_IDX_RANGE;
               end else if (local_op_e'(bus.req_op) == LOCAL_RSVD) begin
                  bus.done = 1'b1;
               end else begin
                  op_d    = local_op_e'(bus.req_op);
                  idx_d   = bus.req_idx;
                  state_d = StAccess;
               end
            end
         end
         StAccess: begin
            bus.mem_addr = base_q + idx_q;
            if (op_q == LOCAL_GET) begin
               data_d  = bus.mem_rd_data;
               state_d = StPush;
            end else begin
               bus.mem_we      = 1'b1;
               bus.mem_wr_data = bus.st_top_data;
               bus.st_pop      = (op_q == LOCAL_SET);
               bus.done        = 1'b1;
               state_d         = StIdle;
            end
         end
         StPush: begin
            bus.st_push = 1'b1;
            bus.done    = 1'b1;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // An op interrupted by reset must not write memory or touch the stack.
      if (rst) begin
         fs_push       = 1'b0;
         fs_pop        = 1'b0;
         bus.mem_we    = 1'b0;
         bus.st_pop    = 1'b0;
         bus.st_push   = 1'b0;
         bus.done      = 1'b0;
         bus.trap      = 1'b0;
         bus.trap_code = TRAP_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         op_q      <= LOCAL_GET;
         idx_q     <= '0;
         base_q    <= '0;
         nlocals_q <= IDX_WIDTH'(INIT_NLOCALS);
         data_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         idx_q     <= idx_d;
         base_q    <= base_d;
         nlocals_q <= nlocals_d;
         data_q    <= data_d;
         addr_q    <= bus.mem_addr;
         wdata_q   <= bus.mem_wr_data;
      end
   end

endmodule

// File: tb/tb_wasm_local_ctrl.sv
// tb_wasm_local_ctrl: directed bench for wasm_local_ctrl with a frame/memory model and a
// per-cycle compare against scheduled expectations.
module tb_wasm_local_ctrl;

   localparam int unsigned DW = 32;
   localparam int unsigned IW = 32;
   localparam int unsigned FD = 16;
`ifdef LOCAL_BOUNDS_CHECK_EN
   localparam bit BCHK = 1'b1;
`else
   localparam bit BCHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wasm_local_ctrl_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

   wasm_local_ctrl #(
      .DATA_WIDTH   (DW),
      .IDX_WIDTH    (IW),
      .FRAME_DEPTH  (FD),
      .INIT_NLOCALS (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Local BRAM: combinational read, clocked write.
   logic [31:0] mem [0:63];
   logic        load_en;
   assign bus.mem_rd_data = mem[bus.mem_addr[5:0]];
   always @(posedge clk) begin
      if (load_en) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
         mem[0] <= 32'd10;
         mem[1] <= 32'd6;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr[5:0]] <= bus.mem_wr_data;
      end
   end

   // Model state.
   logic [31:0] mm [0:63];
   logic [31:0] m_base, m_nl;
   logic [31:0] fs_base [$];
   logic [31:0] fs_nl [$];

   typedef struct packed {
      logic        we;
      logic        pop;
      logic        push;
      logic        done;
      logic        trap;
      logic [1:0]  tc;
      logic        chk_addr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] pd;
   } exp_t;

   exp_t ex  [0:4095];
   logic exv [0:4095];

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic chk_en = 1'b0;
   logic [31:0] last_push  = '0;
   logic [31:0] last_waddr = '0;
   logic [1:0]  last_tc    = '0;
   exp_t cmp_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int c, input exp_t e);
      ex[c % 4096]  = e;
      exv[c % 4096] = 1'b1;
   endtask

   // Every cycle: strobes must match the schedule (all low when nothing is scheduled).
   always @(negedge clk) begin
      if (chk_en) begin
         cmp_e = '0;
         if (exv[cyc % 4096]) cmp_e = ex[cyc % 4096];
         check("strobes", {27'd0, bus.mem_we, bus.st_pop, bus.st_push, bus.done, bus.trap},
               {27'd0, cmp_e.we, cmp_e.pop, cmp_e.push, cmp_e.done, cmp_e.trap});
         check("trap_code", {30'd0, bus.trap_code}, {30'd0, cmp_e.trap ? cmp_e.tc : 2'd0});
         if (cmp_e.we) begin
            check("wr_addr", bus.mem_addr, cmp_e.addr);
            check("wr_data", bus.mem_wr_data, cmp_e.wd);
         end
         if (cmp_e.chk_addr) check("rd_addr", bus.mem_addr, cmp_e.addr);
         if (cmp_e.push) check("push_data", bus.st_push_data, cmp_e.pd);
         if (bus.st_push) last_push = bus.st_push_data;
         if (bus.mem_we) last_waddr = bus.mem_addr;
         if (bus.trap) last_tc = bus.trap_code;
      end
   end

   // Issue one local op from IDLE and return when the controller is idle again.
   task automatic do_op(input logic [1:0] op, input logic [31:0] idx, input logic [31:0] top);
      int c;
      logic [31:0] a;
      exp_t e;
      c = cyc;
      a = m_base + idx;
      e = '0;
      bus.req_vld     = 1'b1;
      bus.req_op      = op;
      bus.req_idx     = idx;
      bus.st_top_data = top;
      if (BCHK && idx >= m_nl) begin
         e.trap = 1'b1;
         e.tc   = 2'd3;
         put(c, e);
         step();
         bus.req_vld = 1'b0;
      end else if (op == 2'd3) begin
         e.done = 1'b1;
         put(c, e);
         step();
         bus.req_vld = 1'b0;
      end else if (op == 2'd0) begin
         e.chk_addr = 1'b1;
         e.addr     = a;
         put(c + 1, e);
         e      = '0;
         e.push = 1'b1;
         e.done = 1'b1;
         e.pd   = mm[a[5:0]];
         put(c + 2, e);
         step();
         bus.req_vld = 1'b0;
         check("rdy_busy", {31'd0, bus.req_rdy}, 32'd0);
         step();
         step();
      end else begin
         e.we   = 1'b1;
         e.addr = a;
         e.wd   = top;
         e.pop  = (op == 2'd1);
         e.done = 1'b1;
         put(c + 1, e);
         mm[a[5:0]] = top;
         step();
         bus.req_vld = 1'b0;
         check("rdy_busy", {31'd0, bus.req_rdy}, 32'd0);
         step();
      end
   endtask

   task automatic do_call(input logic [31:0] n, input logic with_ret);
      int c;
      exp_t e;
      c = cyc;
      e = '0;
      bus.call_vld     = 1'b1;
      bus.call_nlocals = n;
      bus.ret_vld      = with_ret;
      #1;
      check("rdy_frame", {31'd0, bus.req_rdy}, 32'd0);
      if (fs_base.size() == FD) begin
         e.trap = 1'b1;
         e.tc   = 2'd1;
      end else begin
         fs_base.push_back(m_base);
         fs_nl.push_back(m_nl);
         m_base = m_base + m_nl;
         m_nl   = n;
         e.done = 1'b1;
      end
      put(c, e);
      step();
      bus.call_vld = 1'b0;
      bus.ret_vld  = 1'b0;
   endtask

   task automatic do_ret();
      int c;
      exp_t e;
      c = cyc;
      e = '0;
      bus.ret_vld = 1'b1;
      if (fs_base.size() == 0) begin
         e.trap = 1'b1;
         e.tc   = 2'd2;
      end else begin
         m_base = fs_base.pop_back();
         m_nl   = fs_nl.pop_back();
         e.done = 1'b1;
      end
      put(c, e);
      step();
      bus.ret_vld = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rdy"}, {31'd0, bus.req_rdy}, 32'd1);
      check({tag, "_strobes"}, {27'd0, bus.mem_we, bus.st_pop, bus.st_push, bus.done, bus.trap},
            32'd0);
      check({tag, "_tc"}, {30'd0, bus.trap_code}, 32'd0);
      check({tag, "_addr"}, bus.mem_addr, 32'd0);
      check({tag, "_wdata"}, bus.mem_wr_data, 32'd0);
      check({tag, "_pdata"}, bus.st_push_data, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4096; i++) exv[i] = 1'b0;
      for (int i = 0; i < 64; i++) mm[i] = 32'd0;
      mm[0]  = 32'd10;
      mm[1]  = 32'd6;
      m_base = 32'd0;
      m_nl   = 32'd2;
      rst = 1'b1;
      load_en = 1'b1;
      bus.req_vld = 1'b0;
      bus.req_op = 2'd0;
      bus.req_idx = '0;
      bus.call_vld = 1'b0;
      bus.call_nlocals = '0;
      bus.ret_vld = 1'b0;
      bus.st_top_data = '0;
      repeat (3) step();
      rst = 1'b0;
      load_en = 1'b0;
      check_reset_outputs("reset");
      chk_en = 1'b1;
      step();

      // GET idx 1 reads the preloaded 6.
      do_op(2'd0, 32'd1, 32'd0);
      check("get1_literal", last_push, 32'd6);

      // SET idx 0 with 0x55, then read it back immediately.
      do_op(2'd1, 32'd0, 32'h55);
      check("set0_addr_literal", last_waddr, 32'd0);
      do_op(2'd0, 32'd0, 32'd0);
      check("get0_literal", last_push, 32'h55);

      // TEE idx 1 with 7 keeps the value on the stack.
      do_op(2'd2, 32'd1, 32'd7);
      step();
      check("tee_mem_literal", mem[1], 32'd7);
      do_op(2'd0, 32'd1, 32'd0);
      check("get_after_tee_literal", last_push, 32'd7);

      // Reserved op: done only.
      do_op(2'd3, 32'd0, 32'd0);

      // New frame of 3 locals: base becomes 2.
      do_call(32'd3, 1'b0);
      do_op(2'd1, 32'd0, 32'h11);
      check("call_addr_literal", last_waddr, 32'd2);
      do_ret();
      do_op(2'd1, 32'd1, 32'h22);
      check("ret_addr_literal", last_waddr, 32'd1);
      do_op(2'd0, 32'd1, 32'd0);

      // Fill the frame stack, then overflow.
      for (int i = 0; i < 16; i++) do_call(32'd1, 1'b0);
      do_call(32'd1, 1'b0);
      check("ovf_code_literal", {30'd0, last_tc}, 32'd1);
      do_op(2'd1, 32'd0, 32'h99);
      check("ovf_base_literal", last_waddr, 32'd17);
      for (int i = 0; i < 16; i++) do_ret();
      do_ret();
      check("unf_code_literal", {30'd0, last_tc}, 32'd2);

      // Call and ret together: the call wins.
      do_call(32'd4, 1'b1);
      do_op(2'd1, 32'd0, 32'h33);
      check("callret_addr_literal", last_waddr, 32'd2);
      do_ret();

      // Index 2 in a 2-local frame.
`ifdef LOCAL_BOUNDS_CHECK_EN
      do_op(2'd0, 32'd2, 32'd0);
      check("bounds_code_literal", {30'd0, last_tc}, 32'd3);
`else
      do_op(2'd0, 32'd2, 32'd0);
      check("oob_get_literal", last_push, 32'h33);
`endif

      // Reset during ACCESS of a SET: no write, outputs back to reset values.
      bus.req_vld     = 1'b1;
      bus.req_op      = 2'd1;
      bus.req_idx     = 32'd0;
      bus.st_top_data = 32'hAA;
      step();
      bus.req_vld = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      m_base = 32'd0;
      m_nl   = 32'd2;
      fs_base.delete();
      fs_nl.delete();
      check_reset_outputs("midrst");
      step();
      check("midrst_mem_literal", mem[0], 32'h55);
      do_op(2'd0, 32'd0, 32'd0);
      do_ret();
      check("post_rst_unf_literal", {30'd0, last_tc}, 32'd2);

      step();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
